mux8lut_rr_sequencer: RTL and testbench
=======================================

Name: mux8lut_rr_sequencer

Overview:
Round-robin arbiter and sequencer that shares one MUX8LUT_frame_config_mux, configured as an 8:1 mux, between eight requesters wired to inputs A..H. It grants one requester at a time and drives the mux select bus S[3:0] so that M_AH carries the owner's signal. It enforces a bounded hold time and inserts one dead cycle between owners so the mux output can settle. It sits in the LUT4AB tile fabric logic next to the mux BEL and is clocked by the user clock.

Parameters:
MAX_HOLD, 16, maximum cycles one owner may hold the grant (legal range 2..256)
HOLD_W, 8, hold-counter width; must satisfy 2^HOLD_W >= MAX_HOLD

Ports:
UserCLK  input  1  user clock; all state updates on the rising edge
RST  input  1  reset, synchronous, active-high
en  input  1  arbitration enable; when low, no new grants are issued
req  input  8  request vector; bit i corresponds to mux input i (A=0 … H=7)
done  input  1  single-cycle release pulse from the current owner
gnt  output  8  one-hot grant; all zero when there is no owner
gnt_id  output  3  index of the current or last owner
busy  output  1  high while any gnt bit is set
S  output  4  mux select bus, driven to the MUX8LUT S port
timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit

Behaviour:
- Mux assumption: the MUX8LUT is configured with c0=1 and c1=1 (ConfigBits = 2'b11), so M_AH = input[{S[3],S[1],S[0]}] and S[2] has no effect.
- Select encoding for owner index k: S[0]=k[0], S[1]=k[1], S[3]=k[2], S[2]=0.
- Reset state: gnt=0, gnt_id=3'd7, busy=0, S=4'b0000, timeout=0, hold counter=0, state IDLE. The last-owner pointer resets to 7, so index 0 has highest priority after reset.
- FSM states: IDLE, GRANT, GAP.
- IDLE:
  - When en=1 and req!=0, pick the first set bit scanning upward from (last_owner+1) mod 8, with wrap-around.
  - On the next edge: gnt=onehot(k), gnt_id=k, S=enc(k), busy=1, hold=0, go to GRANT.
  - Latency from req to gnt is one cycle.
- GRANT:
  - The hold counter increments every cycle.
  - Release occurs on any of: done=1; req[gnt_id]=0; hold==MAX_HOLD-1.
  - On release, on the next edge: gnt=0, busy=0, go to GAP.
  - S and gnt_id keep the previous owner's value through the release.
  - timeout pulses high in the GAP cycle only when the release cause was the hold limit alone.
- Simultaneous release causes:
  - done together with the hold limit counts as a normal release; no timeout pulse.
  - Deasserted req together with the hold limit also gives no timeout pulse.
- GAP: exactly one cycle with no grant, then go to IDLE. A requester may re-request immediately, but it has lowest priority because last_owner now equals its index.
- Pipelining: arbitration is evaluated in IDLE only, so the minimum spacing between grant starts is 3 cycles (GRANT ≥1 cycle, GAP 1, IDLE 1).
- en=0 during GRANT: the current owner keeps the grant until a normal release; no new grant follows while en=0.
- en=0 in IDLE: the FSM stays in IDLE and req is ignored.
- done outside GRANT: ignored.
- Changes to req bits other than the owner's during GRANT: no effect until the next IDLE.
- RST=1 in any state: return to the reset state on that edge, overriding all other inputs. The last-owner pointer also resets.
- The hold counter never wraps; the release at MAX_HOLD-1 prevents overflow.

Test Plan:
1. After RST, apply req=8'h81, en=1 → next cycle gnt=8'h01, gnt_id=0, S=4'b0000. Pulse done → GAP, then gnt=8'h80, gnt_id=7, S=4'b1011.
2. Hold req=8'hFF and pulse done 2 cycles after each grant → grant order 0,1,…,7,0, with exactly 1 gnt=0 cycle plus 1 IDLE cycle between owners.
3. MAX_HOLD=16, req=8'h04 held, no done → gnt=8'h04 for exactly 16 cycles, then gnt=0 and timeout=1 for 1 cycle, then regrant of index 2 (sole requester).
4. Assert done in the same cycle hold==15 → release with timeout=0.
5. Drop en in the middle of a grant to index 3, with req=8'hFF → owner 3 keeps the grant until done; afterwards gnt stays 0. Raise en → index 4 is granted.
6. Assert RST mid-GRANT with gnt=8'h20 → next cycle all outputs at reset values. Then req=8'h60 → gnt=8'h20 (priority restarts from index 0).

Source files
------------

// File: rtl/mux8lut_rr_sequencer.sv
// mux8lut_rr_sequencer
//   Round-robin arbiter that time-shares one MUX8LUT (ConfigBits=2'b11, 8:1
//   mode) among eight requesters on inputs A..H. It grants one owner at a
//   time and drives the mux select so M_AH carries that owner. Each grant is
//   capped at MAX_HOLD cycles. One dead cycle separates consecutive owners so
//   the mux output can settle.
//
// Ports
//   UserCLK  in   user clock, rising edge
//   RST      in   synchronous active-high reset
//   en       in   arbitration enable (gates new grants only)
//   req[7:0] in   request vector, bit i = mux input i (A=0 .. H=7)
//   done     in   single-cycle release pulse from the current owner
//   gnt[7:0] out  one-hot grant, zero when there is no owner
//   gnt_id   out  index of the current or most recent owner
//   busy     out  high while a grant is active
//   S[3:0]   out  MUX8LUT select bus
//   timeout  out  one-cycle pulse after a hold-limit revoke
module mux8lut_rr_sequencer #(
  parameter int MAX_HOLD = 16,
  parameter int HOLD_W   = 8
) (
  input  logic       UserCLK,
  input  logic       RST,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       done,
  output logic [7:0] gnt,
  output logic [2:0] gnt_id,
  output logic       busy,
  output logic [3:0] S,
  output logic       timeout
);

  typedef enum logic [1:0] {IDLE, GRANT, GAP} state_e;

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);

  state_e            state_q, state_d;
  logic [2:0]        gnt_id_q, gnt_id_d;
  logic [3:0]        s_q, s_d;
  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  // Rotating priority: scan upward from the slot after the last owner. The
  // i=8 step lands back on the last owner itself, giving it lowest priority.
  logic       pick_vld;
  logic [2:0] pick_id;
  logic [2:0] scan_idx;

  always_comb begin
    pick_vld = 1'b0;
    pick_id  = gnt_id_q;
    scan_idx = gnt_id_q;
    for (int i = 1; i <= 8; i++) begin
      scan_idx = gnt_id_q + 3'(i);
      if (!pick_vld && req[scan_idx]) begin
        pick_vld = 1'b1;
        pick_id  = scan_idx;
      end
    end
  end

  logic rel_done, rel_req, at_limit;

  always_comb begin
    state_d   = state_q;
    gnt_id_d  = gnt_id_q;
    s_d       = s_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    rel_done  = done;
    rel_req   = !req[gnt_id_q];
    at_limit  = (hold_q == HOLD_LAST);
    unique case (state_q)
      IDLE: begin
        if (en && pick_vld) begin
          state_d  = GRANT;
          gnt_id_d = pick_id;
          // S[2] is a don't-care in 8:1 mode; tie it low.
          s_d      = {pick_id[2], 1'b0, pick_id[1:0]};
          hold_d   = '0;
        end
      end
      GRANT: begin
        if (rel_done || rel_req || at_limit) begin
          state_d   = GAP;
          hold_d    = '0;
          // Only flag a revoke when the limit was the sole reason to release.
          timeout_d = at_limit && !rel_done && !rel_req;
        end else begin
          hold_d = hold_q + HOLD_ONE;
        end
      end
      GAP:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge UserCLK) begin
    if (RST) begin
      state_q   <= IDLE;
      gnt_id_q  <= 3'd7;
      s_q       <= 4'b0000;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_id_q  <= gnt_id_d;
      s_q       <= s_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign busy    = (state_q == GRANT);
  assign gnt     = busy ? (8'd1 << gnt_id_q) : 8'd0;
  assign gnt_id  = gnt_id_q;
  assign S       = s_q;
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mux8lut_rr_sequencer.sv
module tb_mux8lut_rr_sequencer;
  localparam int MAX_HOLD = 16;

  logic       clk = 1'b0;
  logic       rst, en, done;
  logic [7:0] req;
  logic [7:0] gnt;
  logic [2:0] gnt_id;
  logic       busy, timeout;
  logic [3:0] S;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  mux8lut_rr_sequencer #(.MAX_HOLD(MAX_HOLD), .HOLD_W(8)) dut (
    .UserCLK(clk), .RST(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_id(gnt_id), .busy(busy), .S(S), .timeout(timeout)
  );

  // Reference model: phase 0=idle 1=granted 2=gap, owner = last/current index.
  int m_ph = 0, m_own = 7, m_hold = 0, m_to = 0, m_s = 0;

  task automatic model_step();
    int k;
    bit found;
    if (rst) begin
      m_ph = 0; m_own = 7; m_hold = 0; m_to = 0; m_s = 0;
    end else if (m_ph == 0) begin
      m_to  = 0;
      found = 0;
      if (en) begin
        for (int i = 1; i <= 8; i++) begin
          k = (m_own + i) % 8;
          if (!found && req[k]) begin
            found = 1;
            m_own = k;
          end
        end
      end
      if (found) begin
        m_ph   = 1;
        m_hold = 0;
        m_s    = (m_own % 2) + ((m_own / 2) % 2) * 2 + (m_own / 4) * 8;
      end
    end else if (m_ph == 1) begin
      if (done || !req[m_own] || m_hold == MAX_HOLD - 1) begin
        m_to   = (m_hold == MAX_HOLD - 1 && !done && req[m_own]) ? 1 : 0;
        m_ph   = 2;
        m_hold = 0;
      end else begin
        m_hold++;
        m_to = 0;
      end
    end else begin
      m_ph = 0;
      m_to = 0;
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock: advance model, clock DUT, compare every output against the model.
  task automatic tick();
    logic [7:0] e_gnt;
    model_step();
    @(posedge clk);
    #1;
    e_gnt = (m_ph == 1) ? (8'd1 << m_own) : 8'd0;
    chk("model.gnt", {24'd0, gnt}, {24'd0, e_gnt});
    chk("model.gnt_id", {29'd0, gnt_id}, m_own);
    chk("model.busy", {31'd0, busy}, (m_ph == 1) ? 1 : 0);
    chk("model.S", {28'd0, S}, m_s);
    chk("model.timeout", {31'd0, timeout}, m_to);
  endtask

  task automatic do_reset();
    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  typedef struct {
    logic       rst;
    logic       en;
    logic [7:0] req;
    logic       done;
    logic [7:0] gnt;
    logic [2:0] id;
    logic       busy;
    logic [3:0] s;
    logic       to;
  } vec_t;

  vec_t vt[13];

  initial begin
    int n;
    // rst en req done | gnt id busy S to   (outputs seen after the edge)
    vt[0]  = '{1, 0, 8'h00, 0, 8'h00, 3'd7, 0, 4'b0000, 0};
    vt[1]  = '{0, 1, 8'h81, 0, 8'h01, 3'd0, 1, 4'b0000, 0};
    vt[2]  = '{0, 1, 8'h81, 1, 8'h00, 3'd0, 0, 4'b0000, 0};
    vt[3]  = '{0, 1, 8'h81, 0, 8'h00, 3'd0, 0, 4'b0000, 0};
    vt[4]  = '{0, 1, 8'h81, 0, 8'h80, 3'd7, 1, 4'b1011, 0};
    vt[5]  = '{0, 1, 8'h81, 1, 8'h00, 3'd7, 0, 4'b1011, 0};
    vt[6]  = '{0, 0, 8'h81, 0, 8'h00, 3'd7, 0, 4'b1011, 0};
    vt[7]  = '{0, 0, 8'h81, 0, 8'h00, 3'd7, 0, 4'b1011, 0};
    vt[8]  = '{0, 1, 8'h81, 0, 8'h01, 3'd0, 1, 4'b0000, 0};
    vt[9]  = '{1, 1, 8'h81, 0, 8'h00, 3'd7, 0, 4'b0000, 0};
    vt[10] = '{0, 1, 8'h60, 0, 8'h20, 3'd5, 1, 4'b1001, 0};
    vt[11] = '{1, 1, 8'h60, 0, 8'h00, 3'd7, 0, 4'b0000, 0};
    vt[12] = '{0, 1, 8'h60, 0, 8'h20, 3'd5, 1, 4'b1001, 0};

    rst = 1'b1; en = 1'b0; req = 8'h00; done = 1'b0;
    for (int i = 0; i < 13; i++) begin
      rst = vt[i].rst; en = vt[i].en; req = vt[i].req; done = vt[i].done;
      tick();
      chk($sformatf("vec%0d.gnt", i), {24'd0, gnt}, {24'd0, vt[i].gnt});
      chk($sformatf("vec%0d.gnt_id", i), {29'd0, gnt_id}, {29'd0, vt[i].id});
      chk($sformatf("vec%0d.busy", i), {31'd0, busy}, {31'd0, vt[i].busy});
      chk($sformatf("vec%0d.S", i), {28'd0, S}, {28'd0, vt[i].s});
      chk($sformatf("vec%0d.timeout", i), {31'd0, timeout}, {31'd0, vt[i].to});
    end

    // Full rotation with req=FF: grants 0..7,0 with two empty cycles between.
    do_reset();
    en = 1'b1; req = 8'hFF;
    tick();
    chk("rot.first", {29'd0, gnt_id}, 0);
    for (int g = 1; g <= 8; g++) begin
      tick();
      done = 1'b1; tick();
      chk("rot.gap", {24'd0, gnt}, 0);
      done = 1'b0; tick();
      chk("rot.idle", {24'd0, gnt}, 0);
      tick();
      chk("rot.id", {29'd0, gnt_id}, g % 8);
      chk("rot.gnt", {24'd0, gnt}, {24'd0, 8'd1 << (g % 8)});
    end

    // Hold limit: sole requester 2 keeps the grant exactly MAX_HOLD cycles.
    do_reset();
    en = 1'b1; req = 8'h04;
    tick();
    n = 0;
    while (gnt === 8'h04 && n < 40) begin
      n++;
      tick();
    end
    chk("hold.len", n, MAX_HOLD);
    chk("hold.to_pulse", {31'd0, timeout}, 1);
    chk("hold.gap_gnt", {24'd0, gnt}, 0);
    tick();
    chk("hold.to_clear", {31'd0, timeout}, 0);
    tick();
    chk("hold.regrant", {24'd0, gnt}, 8'h04);

    // done coinciding with the last hold cycle is a normal release.
    for (int i = 0; i < MAX_HOLD - 1; i++) tick();
    chk("lim_done.still", {24'd0, gnt}, 8'h04);
    done = 1'b1; tick();
    done = 1'b0;
    chk("lim_done.gnt", {24'd0, gnt}, 0);
    chk("lim_done.no_to", {31'd0, timeout}, 0);

    // en dropped mid-grant to 3: owner keeps it, nothing follows until en=1.
    do_reset();
    en = 1'b1; req = 8'hFF;
    tick();
    for (int g = 0; g < 3; g++) begin
      done = 1'b1; tick();
      done = 1'b0; tick();
      tick();
    end
    chk("en.owner3", {24'd0, gnt}, 8'h08);
    en = 1'b0;
    tick(); chk("en.keep1", {24'd0, gnt}, 8'h08);
    tick(); chk("en.keep2", {24'd0, gnt}, 8'h08);
    done = 1'b1; tick();
    done = 1'b0;
    chk("en.rel", {24'd0, gnt}, 0);
    for (int i = 0; i < 3; i++) begin
      tick(); chk("en.idle", {24'd0, gnt}, 0);
    end
    en = 1'b1; tick();
    chk("en.next_gnt", {24'd0, gnt}, 8'h10);
    chk("en.next_id", {29'd0, gnt_id}, 4);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 4000; c++) begin
      rst  = ($urandom_range(0, 199) == 0);
      en   = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 15) == 0)
        req = ($urandom_range(0, 1) == 0) ? 8'($urandom) : (8'd1 << $urandom_range(0, 7));
      done = ($urandom_range(0, 19) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
